dmem_bus_master: RTL
====================

Name: dmem_bus_master

Overview:
- Processor-side initiator for the data-memory bus: MREQ/WRITE/SIZE/DAD/DDT with ACKD_n acknowledge.
- Accepts one load/store request from the memory stage over a valid/ready handshake and runs exactly one bus transaction for it.
- Waits for ACKD_n, places store data in the bus lanes, and aligns and extends load data.
- One instance serves each memory port of the dual-issue core.

Parameters:
- BIT_WIDTH, 32, address/data width.
- TIMEOUT, 16, cycles waited for ACKD_n before an error response; 0 disables the timeout.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1=store, 0=load.
- req_size  input  2  00=word, 01=half, 10=byte, 11=illegal.
- req_unsigned  input  1  load zero-extends when 1.
- req_addr  input  BIT_WIDTH  byte address.
- req_wdata  input  BIT_WIDTH  store data, right-aligned.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  BIT_WIDTH  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned/illegal access or timeout.
- DAD  output  BIT_WIDTH  bus address.
- MREQ  output  1  bus request.
- WRITE  output  1  bus write.
- SIZE  output  2  bus size, same encoding as req_size.
- DDT  inout  BIT_WIDTH  bus data.
- ACKD_n  input  1  active-low acknowledge.

Behaviour:
- States: IDLE, BUS, RESP, encoded in 2 bits.
- Reset (async, any state, including mid-transaction):
  - state=IDLE, wait counter=0.
  - MREQ=0, WRITE=0, SIZE=00, DAD=0.
  - DDT released to high-Z.
  - resp_valid=0, resp_err=0, resp_rdata=0, req_ready=1.
- IDLE:
  - req_ready=1; accept on a rising edge with req_valid&&req_ready.
  - Latch write/size/unsigned/addr/wdata on accept.
  - Alignment check at accept. Error when: size=11; half with addr[0]=1; word with addr[1:0]!=00.
  - On error: go to RESP with err=1. No bus cycle is issued and MREQ stays 0.
  - Otherwise go to BUS.
- BUS:
  - MREQ=1, DAD=latched addr, WRITE=latched write, SIZE=latched size. All are registered, so stable for the whole state.
  - req_ready=0.
  - Store: DDT driven every BUS cycle, lanes zero-filled above the access size:
    - word: wdata
    - half: {16'b0, wdata[15:0]}
    - byte: {24'b0, wdata[7:0]}
  - Load: DDT=Z.
  - Each rising edge: if ACKD_n==0, capture DDT (loads) and go to RESP with err=0.
    - Otherwise the wait counter increments.
    - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ack, go to RESP with err=1 and rdata=0.
  - ACKD_n is sampled only in BUS; ACKD_n low in IDLE or RESP is ignored.
- Leaving BUS: MREQ, WRITE and DDT drive drop in the same edge. Counter clears.
- Load data extension (memory returns data right-aligned):
  - byte: signed {{24{d[7]}}, d[7:0]}; unsigned {24'b0, d[7:0]}.
  - half: signed {{16{d[15]}}, d[15:0]}; unsigned {16'b0, d[15:0]}.
  - word: d unchanged.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_rdata/resp_err valid with it.
  - Return to IDLE next edge.
  - req_ready=0 in RESP; no new request is accepted in the response cycle.
- Latency and throughput:
  - accept edge N → BUS; ack at edge N+1 → resp_valid high during cycle N+1..N+2.
  - Minimum 3 cycles per access.
  - Misaligned/illegal: resp_valid in the cycle after accept.
- Wait states: each cycle of ACKD_n high in BUS adds one cycle; the bus outputs hold.
- Counter width: $clog2(TIMEOUT+1), with at least 1 bit.

Test Plan:
- Word load, addr 0x0800_0010, memory returns DDT=0x8123_4567 with ACKD_n=0 on the first BUS cycle:
  - MREQ=1, WRITE=0, SIZE=00 for one cycle.
  - resp_rdata=0x8123_4567, err=0, resp_valid 2 cycles after accept.
- Byte loads returning 0x0000_00F0:
  - signed → 0xFFFF_FFF0; unsigned → 0x0000_00F0.
  - Half returning 0x0000_8001: signed → 0xFFFF_8001.
- Byte store, wdata=0xDEAD_BE41, addr 0xF000_0000, ACKD_n held high 3 cycles then low:
  - DDT=0x0000_0041, SIZE=10, MREQ/WRITE held 4 cycles.
  - resp_err=0; DDT=Z after.
- Misaligned: half at 0x0800_0003, word at 0x0800_0002, size=11.
  - MREQ never asserts; resp_valid with err=1 one cycle after accept.
- Timeout, TIMEOUT=4, ACKD_n stuck high: MREQ high exactly 4 cycles, then resp_err=1, rdata=0, back to IDLE with req_ready=1.
- Reset asserted mid-BUS, asynchronously between edges:
  - MREQ=0 and DDT=Z immediately; no resp_valid.
  - After release, a new word load completes normally.

Source files
------------

// File: rtl/dmem_bus_master.sv
// Data-memory bus initiator: turns one valid/ready load/store request into one
// MREQ/ACKD_n bus transaction, with store lane placement and load extension.
module dmem_bus_master #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [BIT_WIDTH-1:0] req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [BIT_WIDTH-1:0] resp_rdata,
    output logic                 resp_err,
    output logic [BIT_WIDTH-1:0] DAD,
    output logic                 MREQ,
    output logic                 WRITE,
    output logic [1:0]           SIZE,
    inout  wire  [BIT_WIDTH-1:0] DDT,
    input  logic                 ACKD_n
);

    localparam int unsigned CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state,      w_state_nx;
    logic [CNT_W-1:0]     r_cnt,        w_cnt_nx;
    logic                 r_mreq,       w_mreq_nx;
    logic                 r_write,      w_write_nx;
    logic [1:0]           r_size,       w_size_nx;
    logic [BIT_WIDTH-1:0] r_dad,        w_dad_nx;
    logic                 r_uns,        w_uns_nx;
    logic                 r_ddt_oe,     w_ddt_oe_nx;
    logic [BIT_WIDTH-1:0] r_ddt_out,    w_ddt_out_nx;
    logic                 r_req_ready,  w_req_ready_nx;
    logic                 r_resp_valid, w_resp_valid_nx;
    logic                 r_resp_err,   w_resp_err_nx;
    logic [BIT_WIDTH-1:0] r_resp_rdata, w_resp_rdata_nx;

    logic                 w_misalign;
    logic [BIT_WIDTH-1:0] w_store_lanes;
    logic [BIT_WIDTH-1:0] w_load_ext;

    assign w_misalign = (req_size == SZ_ILL)
                     || ((req_size == SZ_HALF) && req_addr[0])
                     || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    // Store data is right-aligned; lanes above the access size go out as zero.
    always_comb begin
        w_store_lanes = req_wdata;
        case (req_size)
            SZ_HALF: w_store_lanes = {{(BIT_WIDTH-16){1'b0}}, req_wdata[15:0]};
            SZ_BYTE: w_store_lanes = {{(BIT_WIDTH-8){1'b0}},  req_wdata[7:0]};
            default: ;
        endcase
    end

    always_comb begin
        w_load_ext = DDT;
        case (r_size)
            SZ_BYTE: w_load_ext = r_uns ? {{(BIT_WIDTH-8){1'b0}}, DDT[7:0]}
                                        : {{(BIT_WIDTH-8){DDT[7]}}, DDT[7:0]};
            SZ_HALF: w_load_ext = r_uns ? {{(BIT_WIDTH-16){1'b0}}, DDT[15:0]}
                                        : {{(BIT_WIDTH-16){DDT[15]}}, DDT[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_mreq_nx       = r_mreq;
        w_write_nx      = r_write;
        w_size_nx       = r_size;
        w_dad_nx        = r_dad;
        w_uns_nx        = r_uns;
        w_ddt_oe_nx     = r_ddt_oe;
        w_ddt_out_nx    = r_ddt_out;
        w_req_ready_nx  = 1'b0;
        w_resp_valid_nx = 1'b0;
        w_resp_err_nx   = 1'b0;
        w_resp_rdata_nx = '0;
        case (r_state)
            S_IDLE: begin
                w_req_ready_nx = 1'b1;
                if (req_valid && r_req_ready) begin
                    w_req_ready_nx = 1'b0;
                    if (w_misalign) begin
                        w_state_nx      = S_RESP;
                        w_resp_valid_nx = 1'b1;
                        w_resp_err_nx   = 1'b1;
                    end else begin
                        w_state_nx   = S_BUS;
                        w_cnt_nx     = '0;
                        w_mreq_nx    = 1'b1;
                        w_write_nx   = req_write;
                        w_size_nx    = req_size;
                        w_dad_nx     = req_addr;
                        w_uns_nx     = req_unsigned;
                        w_ddt_oe_nx  = req_write;
                        w_ddt_out_nx = w_store_lanes;
                    end
                end
            end
            S_BUS: begin
                if (!ACKD_n) begin
                    w_state_nx      = S_RESP;
                    w_resp_valid_nx = 1'b1;
                    w_resp_rdata_nx = r_write ? '0 : w_load_ext;
                    w_cnt_nx        = '0;
                    w_mreq_nx       = 1'b0;
                    w_write_nx      = 1'b0;
                    w_ddt_oe_nx     = 1'b0;
                end else if ((TIMEOUT != 0) && (r_cnt == CNT_W'(TO_LAST))) begin
                    w_state_nx      = S_RESP;
                    w_resp_valid_nx = 1'b1;
                    w_resp_err_nx   = 1'b1;
                    w_cnt_nx        = '0;
                    w_mreq_nx       = 1'b0;
                    w_write_nx      = 1'b0;
                    w_ddt_oe_nx     = 1'b0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_RESP: begin
                w_state_nx     = S_IDLE;
                w_req_ready_nx = 1'b1;
            end
            default: begin
                w_state_nx     = S_IDLE;
                w_req_ready_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mreq       <= 1'b0;
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_dad        <= '0;
            r_uns        <= 1'b0;
            r_ddt_oe     <= 1'b0;
            r_ddt_out    <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_mreq       <= w_mreq_nx;
            r_write      <= w_write_nx;
            r_size       <= w_size_nx;
            r_dad        <= w_dad_nx;
            r_uns        <= w_uns_nx;
            r_ddt_oe     <= w_ddt_oe_nx;
            r_ddt_out    <= w_ddt_out_nx;
            r_req_ready  <= w_req_ready_nx;
            r_resp_valid <= w_resp_valid_nx;
            r_resp_err   <= w_resp_err_nx;
            r_resp_rdata <= w_resp_rdata_nx;
        end
    end

    assign DDT        = r_ddt_oe ? r_ddt_out : 'z;
    assign MREQ       = r_mreq;
    assign WRITE      = r_write;
    assign SIZE       = r_size;
    assign DAD        = r_dad;
    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;

endmodule
